// File: rtl/cnn_ctrl_pkg.sv
// Shared definitions for the convolution-layer control blocks.
// Sequencer states, geometry helpers and derived constants for the default layer.
package cnn_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_e;

    function automatic int out_dim(input int img, input int k);
        return img - k + 1;
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_IMG_W = 32;
    localparam int DEF_IMG_H = 32;
    localparam int DEF_KSIZE = 5;
    localparam int OUT_W     = out_dim(DEF_IMG_W, DEF_KSIZE);
    localparam int OUT_H     = out_dim(DEF_IMG_H, DEF_KSIZE);
    localparam int TAPS      = DEF_KSIZE * DEF_KSIZE;

endpackage

// File: rtl/conv_window_sequencer_if.sv
// Memory-read, MAC-control and output-write strobes driven by the window sequencer.
interface conv_window_sequencer_if #(
    parameter int FEAT_AW = 11,
    parameter int OUT_AW  = 11,
    parameter int WGT_AW  = 5
);
    // Every *_en / mac_* signal is a one-cycle qualifier with no backpressure:
    // an address is meaningful only in the cycle its strobe is high.
    logic              feat_rd_en;
    logic [FEAT_AW-1:0] feat_rd_addr;
    logic [WGT_AW-1:0]  wgt_rd_addr;
    logic              mac_en;
    logic              mac_clear;
    logic              mac_last;
    logic              out_wr_en;
    logic [OUT_AW-1:0]  out_wr_addr;

    modport master (
        output feat_rd_en, feat_rd_addr, wgt_rd_addr,
        output mac_en, mac_clear, mac_last,
        output out_wr_en, out_wr_addr
    );

    modport slave (
        input feat_rd_en, feat_rd_addr, wgt_rd_addr,
        input mac_en, mac_clear, mac_last,
        input out_wr_en, out_wr_addr
    );
endinterface

// File: rtl/conv_tap_counter.sv
// Nested k_col/k_row/out_col/out_row counter producing feature, weight and output
// addresses incrementally from base registers, without a multiplier.
module conv_tap_counter
    import cnn_ctrl_pkg::*;
#(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int KSIZE = 5,
    parameter int FA_W  = 11,
    parameter int OA_W  = 11,
    parameter int WA_W  = 5
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_advance,
    output logic [FA_W-1:0] o_feat_addr,
    output logic [WA_W-1:0] o_wgt_addr,
    output logic [OA_W-1:0] o_out_addr,
    output logic            o_first_tap,
    output logic            o_last_tap,
    output logic            o_frame_last
);
    localparam int OW = out_dim(IMG_W, KSIZE);
    localparam int OH = out_dim(IMG_H, KSIZE);
    localparam int KW = cnt_width(KSIZE);
    localparam int XW = cnt_width(OW);
    localparam int YW = cnt_width(OH);

    localparam logic [KW-1:0]   K_MAX    = KW'(KSIZE - 1);
    localparam logic [XW-1:0]   X_MAX    = XW'(OW - 1);
    localparam logic [YW-1:0]   Y_MAX    = YW'(OH - 1);
    localparam logic [FA_W-1:0] ROW_STEP = FA_W'(IMG_W);

    logic [KW-1:0]   r_k_col;
    logic [KW-1:0]   r_k_row;
    logic [XW-1:0]   r_out_col;
    logic [YW-1:0]   r_out_row;
    logic [FA_W-1:0] r_line_base;  // out_row*IMG_W
    logic [FA_W-1:0] r_win_base;   // window top-left address
    logic [FA_W-1:0] r_row_base;   // window base + k_row*IMG_W
    logic [WA_W-1:0] r_wgt;
    logic [OA_W-1:0] r_out_addr;

    logic w_kc_wrap;
    logic w_kr_wrap;
    logic w_oc_wrap;
    logic w_or_wrap;

    assign w_kc_wrap = (r_k_col == K_MAX);
    assign w_kr_wrap = (r_k_row == K_MAX);
    assign w_oc_wrap = (r_out_col == X_MAX);
    assign w_or_wrap = (r_out_row == Y_MAX);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_k_col     <= '0;
            r_k_row     <= '0;
            r_out_col   <= '0;
            r_out_row   <= '0;
            r_line_base <= '0;
            r_win_base  <= '0;
            r_row_base  <= '0;
            r_wgt       <= '0;
            r_out_addr  <= '0;
        end else if (i_advance) begin
            if (!w_kc_wrap) begin
                r_k_col <= r_k_col + 1'b1;
                r_wgt   <= r_wgt + 1'b1;
            end else begin
                r_k_col <= '0;
                if (!w_kr_wrap) begin
                    r_k_row    <= r_k_row + 1'b1;
                    r_row_base <= r_row_base + ROW_STEP;
                    r_wgt      <= r_wgt + 1'b1;
                end else begin
                    r_k_row <= '0;
                    r_wgt   <= '0;
                    if (!w_oc_wrap) begin
                        r_out_col  <= r_out_col + 1'b1;
                        r_win_base <= r_win_base + 1'b1;
                        r_row_base <= r_win_base + 1'b1;
                        r_out_addr <= r_out_addr + 1'b1;
                    end else begin
                        r_out_col <= '0;
                        if (!w_or_wrap) begin
                            r_out_row   <= r_out_row + 1'b1;
                            r_line_base <= r_line_base + ROW_STEP;
                            r_win_base  <= r_line_base + ROW_STEP;
                            r_row_base  <= r_line_base + ROW_STEP;
                            r_out_addr  <= r_out_addr + 1'b1;
                        end else begin
                            // Frame wraps so the next frame starts from zero.
                            r_out_row   <= '0;
                            r_line_base <= '0;
                            r_win_base  <= '0;
                            r_row_base  <= '0;
                            r_out_addr  <= '0;
                        end
                    end
                end
            end
        end
    end

    assign o_feat_addr  = r_row_base + FA_W'(r_k_col);
    assign o_wgt_addr   = r_wgt;
    assign o_out_addr   = r_out_addr;
    assign o_first_tap  = (r_k_col == '0) && (r_k_row == '0);
    assign o_last_tap   = w_kc_wrap && w_kr_wrap;
    assign o_frame_last = w_kc_wrap && w_kr_wrap && w_oc_wrap && w_or_wrap;

endmodule

// File: rtl/conv_window_sequencer.sv
// Convolution-layer control sequencer: issues window taps, steers the MAC through a
// two-stage control pipeline and writes one output pixel per window.
module conv_window_sequencer
    import cnn_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH            = 16,
    parameter int IN_FEATURE_ADDR_WIDTH = 11,
    parameter int OUT_ADDR_WIDTH        = 11,
    parameter int WEIGHT_ADDR_WIDTH     = 5,
    parameter int IMG_W                 = 32,
    parameter int IMG_H                 = 32,
    parameter int KSIZE                 = 5
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_enable,
    conv_window_sequencer_if.master m_if,
    output logic                    o_busy,
    output logic                    o_done,
    output seq_state_e              o_dbg_state
);
    localparam int OW = out_dim(IMG_W, KSIZE);
    localparam int OH = out_dim(IMG_H, KSIZE);

    if ((IMG_W * IMG_H > 2 ** IN_FEATURE_ADDR_WIDTH) ||
        (OW * OH > 2 ** OUT_ADDR_WIDTH) ||
        (KSIZE * KSIZE > 2 ** WEIGHT_ADDR_WIDTH) ||
        (KSIZE < 1) || (OW < 1) || (OH < 1) || (DATA_WIDTH < 1)) begin : g_param_err
        $error("conv_window_sequencer: geometry does not fit the address widths");
    end

    seq_state_e r_state;
    seq_state_e w_next;
    logic       w_issue;
    logic       w_done;

    logic [IN_FEATURE_ADDR_WIDTH-1:0] w_feat_addr;
    logic [WEIGHT_ADDR_WIDTH-1:0]     w_wgt_addr;
    logic [OUT_ADDR_WIDTH-1:0]        w_out_addr;
    logic                             w_first_tap;
    logic                             w_last_tap;
    logic                             w_frame_last;

    logic                      r_s1_valid;
    logic                      r_s1_first;
    logic                      r_s1_last;
    logic [OUT_ADDR_WIDTH-1:0] r_s1_addr;
    logic                      r_s2_wr;
    logic [OUT_ADDR_WIDTH-1:0] r_s2_addr;

    conv_tap_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .KSIZE (KSIZE),
        .FA_W  (IN_FEATURE_ADDR_WIDTH),
        .OA_W  (OUT_ADDR_WIDTH),
        .WA_W  (WEIGHT_ADDR_WIDTH)
    ) u_tap_counter (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_advance    (w_issue),
        .o_feat_addr  (w_feat_addr),
        .o_wgt_addr   (w_wgt_addr),
        .o_out_addr   (w_out_addr),
        .o_first_tap  (w_first_tap),
        .o_last_tap   (w_last_tap),
        .o_frame_last (w_frame_last)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_enable) w_next = ST_RUN;
            end
            ST_RUN: begin
                w_issue = i_enable;
                if (i_enable && w_frame_last) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!r_s1_valid && !r_s2_wr) begin
                    w_done = 1'b1;
                    w_next = ST_HALT;
                end
            end
            ST_HALT: begin
                // Enable must drop before another frame may start.
                if (!i_enable) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Stages run freely so taps issued before a stall always finish.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_addr  <= '0;
            r_s2_wr    <= 1'b0;
            r_s2_addr  <= '0;
        end else begin
            r_s1_valid <= w_issue;
            r_s1_first <= w_issue && w_first_tap;
            r_s1_last  <= w_issue && w_last_tap;
            r_s1_addr  <= w_out_addr;
            r_s2_wr    <= r_s1_valid && r_s1_last;
            r_s2_addr  <= r_s1_addr;
        end
    end

    assign m_if.feat_rd_en   = w_issue;
    assign m_if.feat_rd_addr = w_feat_addr;
    assign m_if.wgt_rd_addr  = w_wgt_addr;
    assign m_if.mac_en       = r_s1_valid;
    assign m_if.mac_clear    = r_s1_first;
    assign m_if.mac_last     = r_s1_last;
    assign m_if.out_wr_en    = r_s2_wr;
    assign m_if.out_wr_addr  = r_s2_addr;

    assign o_busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign o_done      = w_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer: a 4x4/K=3 instance and a default 32x32/K=5 instance,
// checked against address and timing lists computed from the window arithmetic.
module tb_conv_window_sequencer;
  import cnn_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic en_s;
  logic en_d;
  logic busy_s, done_s, busy_d, done_d;
  seq_state_e st_s, st_d;

  conv_window_sequencer_if if_s();
  conv_window_sequencer_if if_d();

  conv_window_sequencer #(.IMG_W(4), .IMG_H(4), .KSIZE(3)) dut_s (
    .i_clock(clk), .i_reset(rst_n), .i_enable(en_s), .m_if(if_s),
    .o_busy(busy_s), .o_done(done_s), .o_dbg_state(st_s)
  );

  conv_window_sequencer dut_d (
    .i_clock(clk), .i_reset(rst_n), .i_enable(en_d), .m_if(if_d),
    .o_busy(busy_d), .o_done(done_d), .o_dbg_state(st_d)
  );

  int total = 0;
  int bad = 0;
  int sel = 0;

  logic c_fe, c_me, c_mc, c_ml, c_we, c_busy, c_done;
  logic [10:0] c_fa;
  logic [10:0] c_wo;
  logic [4:0] c_wg;

  always_comb begin
    if (sel == 1) begin
      c_fe = if_d.feat_rd_en; c_fa = if_d.feat_rd_addr; c_wg = if_d.wgt_rd_addr;
      c_me = if_d.mac_en; c_mc = if_d.mac_clear; c_ml = if_d.mac_last;
      c_we = if_d.out_wr_en; c_wo = if_d.out_wr_addr; c_busy = busy_d; c_done = done_d;
    end else begin
      c_fe = if_s.feat_rd_en; c_fa = if_s.feat_rd_addr; c_wg = if_s.wgt_rd_addr;
      c_me = if_s.mac_en; c_mc = if_s.mac_clear; c_ml = if_s.mac_last;
      c_we = if_s.out_wr_en; c_wo = if_s.out_wr_addr; c_busy = busy_s; c_done = done_s;
    end
  end

  // ---------------- reference model ----------------
  logic [10:0] exp_feat_q[$];
  logic [4:0]  exp_wgt_q[$];
  bit          exp_clr_q[$];
  bit          exp_last_q[$];
  logic [10:0] exp_wr_q[$];
  int          m_taps;

  task automatic build_model(input int s);
    int iw, ih, k, ow, oh;
    iw = (s == 1) ? 32 : 4;
    ih = (s == 1) ? 32 : 4;
    k  = (s == 1) ? 5 : 3;
    ow = iw - k + 1;
    oh = ih - k + 1;
    m_taps = k * k;
    exp_feat_q.delete(); exp_wgt_q.delete(); exp_clr_q.delete();
    exp_last_q.delete(); exp_wr_q.delete();
    for (int orow = 0; orow < oh; orow++)
      for (int ocol = 0; ocol < ow; ocol++) begin
        for (int kr = 0; kr < k; kr++)
          for (int kc = 0; kc < k; kc++) begin
            exp_feat_q.push_back(11'((orow + kr) * iw + ocol + kc));
            exp_wgt_q.push_back(5'(kr * k + kc));
            exp_clr_q.push_back(kr == 0 && kc == 0);
            exp_last_q.push_back(kr == k - 1 && kc == k - 1);
          end
        exp_wr_q.push_back(11'(orow * ow + ocol));
      end
  endtask

  // ---------------- observation / driver ----------------
  logic [10:0] obs_feat_q[$];
  logic [4:0]  obs_wgt_q[$];
  int          obs_iss_cyc[$];
  int          obs_mac_cyc[$];
  bit          obs_clr_q[$];
  bit          obs_last_q[$];
  logic [10:0] obs_wr_q[$];
  int          obs_wr_cyc[$];
  int          obs_done_q[$];
  int          post_iss, first_busy, last_busy, busy_cnt;

  // mode: 0 steady enable, 1 random enable, 2 stall after tap stall_at, 3 enable low after final tap
  task automatic run_frame(input int s, input int mode, input int stall_at, input int stall_len,
                           input logic post_en, input int tail, input int budget);
    int n_iss, stalled, after;
    bit seen;
    logic en;
    sel = s;
    obs_feat_q.delete(); obs_wgt_q.delete(); obs_iss_cyc.delete(); obs_mac_cyc.delete();
    obs_clr_q.delete(); obs_last_q.delete(); obs_wr_q.delete(); obs_wr_cyc.delete();
    obs_done_q.delete();
    n_iss = 0; stalled = 0; after = 0; seen = 0;
    post_iss = 0; first_busy = -1; last_busy = -1; busy_cnt = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (seen) en = post_en;
      else begin
        case (mode)
          1: en = ($urandom_range(0, 3) != 0);
          2: begin
            if (n_iss == stall_at && stalled < stall_len) begin en = 1'b0; stalled++; end
            else en = 1'b1;
          end
          3: en = (n_iss < exp_feat_q.size());
          default: en = 1'b1;
        endcase
      end
      if (s == 1) en_d = en; else en_s = en;
      #1;
      if (c_fe) begin
        if (seen) post_iss++;
        else begin
          obs_feat_q.push_back(c_fa); obs_wgt_q.push_back(c_wg); obs_iss_cyc.push_back(c);
          n_iss++;
        end
      end
      if (c_me) begin obs_mac_cyc.push_back(c); obs_clr_q.push_back(c_mc); obs_last_q.push_back(c_ml); end
      if (c_we) begin obs_wr_q.push_back(c_wo); obs_wr_cyc.push_back(c); end
      if (c_busy) begin
        if (first_busy < 0) first_busy = c;
        last_busy = c;
        busy_cnt++;
      end
      if (c_done) begin obs_done_q.push_back(c); seen = 1; end
      if (seen) begin
        if (after >= tail) break;
        after++;
      end
    end
  endtask

  // First index where observed and model lists disagree; -1 when identical, -2 on length mismatch.
  function automatic int feat_diff();
    if (obs_feat_q.size() != exp_feat_q.size()) return -2;
    foreach (exp_feat_q[i]) if (obs_feat_q[i] !== exp_feat_q[i]) return i;
    return -1;
  endfunction

  function automatic int wgt_diff();
    if (obs_wgt_q.size() != exp_wgt_q.size()) return -2;
    foreach (exp_wgt_q[i]) if (obs_wgt_q[i] !== exp_wgt_q[i]) return i;
    return -1;
  endfunction

  function automatic int mac_diff();
    if (obs_mac_cyc.size() != exp_clr_q.size() || obs_iss_cyc.size() != exp_clr_q.size()) return -2;
    foreach (exp_clr_q[i])
      if (obs_mac_cyc[i] != obs_iss_cyc[i] + 1 || obs_clr_q[i] != exp_clr_q[i] ||
          obs_last_q[i] != exp_last_q[i]) return i;
    return -1;
  endfunction

  function automatic int wr_diff();
    int ti;
    if (obs_wr_q.size() != exp_wr_q.size()) return -2;
    foreach (exp_wr_q[j]) begin
      ti = j * m_taps + m_taps - 1;
      if (obs_wr_q[j] !== exp_wr_q[j]) return j;
      if (ti >= obs_iss_cyc.size()) return j;
      if (obs_wr_cyc[j] != obs_iss_cyc[ti] + 2) return j;
    end
    return -1;
  endfunction

  function automatic int last_iss();
    return (obs_iss_cyc.size() > 0) ? obs_iss_cyc[obs_iss_cyc.size() - 1] : -1000;
  endfunction

  function automatic int first_done();
    return (obs_done_q.size() > 0) ? obs_done_q[0] : -2000;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [33:0] snap;
    logic pre_busy;
    bit got;
    rst_n = 1'b0; en_s = 1'b0; en_d = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    snap = {if_s.feat_rd_en, if_s.feat_rd_addr, if_s.wgt_rd_addr, if_s.mac_en, if_s.mac_clear,
            if_s.mac_last, if_s.out_wr_en, if_s.out_wr_addr, busy_s, done_s};
    if (snap !== 34'd0) begin bad++; $display("FAIL reset_small_outputs: got %h want 0", snap); end
    total++;
    snap = {if_d.feat_rd_en, if_d.feat_rd_addr, if_d.wgt_rd_addr, if_d.mac_en, if_d.mac_clear,
            if_d.mac_last, if_d.out_wr_en, if_d.out_wr_addr, busy_d, done_d};
    if (snap !== 34'd0) begin bad++; $display("FAIL reset_default_outputs: got %h want 0", snap); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); en_d = 1'b1;
    repeat (40) @(negedge clk);
    #2;
    pre_busy = busy_d;
    total++;
    if (pre_busy !== 1'b1) begin bad++; $display("FAIL reset_prerun_busy: got %b want 1", pre_busy); end
    rst_n = 1'b0;
    #1;
    total++;
    snap = {if_d.feat_rd_en, if_d.feat_rd_addr, if_d.wgt_rd_addr, if_d.mac_en, if_d.mac_clear,
            if_d.mac_last, if_d.out_wr_en, if_d.out_wr_addr, busy_d, done_d};
    if (snap !== 34'd0 || st_d !== ST_IDLE) begin
      bad++; $display("FAIL reset_midrun_async: got %h state %0d want 0 state 0", snap, st_d);
    end
    repeat (2) @(negedge clk);
    #1;
    total++;
    snap = {if_d.feat_rd_en, if_d.feat_rd_addr, if_d.wgt_rd_addr, if_d.mac_en, if_d.mac_clear,
            if_d.mac_last, if_d.out_wr_en, if_d.out_wr_addr, busy_d, done_d};
    if (snap !== 34'd0) begin bad++; $display("FAIL reset_held: got %h want 0", snap); end
    @(negedge clk); rst_n = 1'b1;
    got = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (if_d.feat_rd_en) begin got = 1; break; end
    end
    total++;
    if (!got || if_d.feat_rd_addr !== 11'd0 || if_d.wgt_rd_addr !== 5'd0) begin
      bad++;
      $display("FAIL reset_restart_addr: got en=%b feat=%0d wgt=%0d want en=1 feat=0 wgt=0",
               got, if_d.feat_rd_addr, if_d.wgt_rd_addr);
    end
    en_d = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_small_constant();
    int d;
    build_model(0);
    run_frame(0, 0, 0, 0, 1'b0, 4, 400);
    total++;
    if (obs_feat_q.size() != 36) begin bad++; $display("FAIL small_issue_count: got %0d want 36", obs_feat_q.size()); end
    total++; d = feat_diff();
    if (d != -1) begin bad++; $display("FAIL small_feat_seq: bad index %0d want -1", d); end
    total++;
    if (obs_feat_q.size() < 10 || obs_feat_q[9] !== 11'd1) begin
      bad++; $display("FAIL small_second_window: got size %0d want feat[9]=1", obs_feat_q.size());
    end
    total++; d = wgt_diff();
    if (d != -1) begin bad++; $display("FAIL small_wgt_seq: bad index %0d want -1", d); end
    total++; d = mac_diff();
    if (d != -1) begin bad++; $display("FAIL small_mac_seq: bad index %0d want -1", d); end
    total++; d = wr_diff();
    if (d != -1) begin bad++; $display("FAIL small_wr_seq: bad index %0d want -1", d); end
    total++;
    if (obs_done_q.size() != 1) begin bad++; $display("FAIL small_done_count: got %0d want 1", obs_done_q.size()); end
    total++;
    if (first_done() - last_iss() != 3) begin
      bad++; $display("FAIL small_done_latency: got %0d want 3", first_done() - last_iss());
    end
    total++;
    if (last_iss() - obs_iss_cyc[0] != 35) begin
      bad++; $display("FAIL small_issue_span: got %0d want 35", last_iss() - obs_iss_cyc[0]);
    end
    total++;
    if (first_busy != obs_iss_cyc[0] || last_busy != first_done() || busy_cnt != last_busy - first_busy + 1) begin
      bad++; $display("FAIL small_busy_window: got %0d..%0d n=%0d want %0d..%0d contiguous",
                      first_busy, last_busy, busy_cnt, obs_iss_cyc[0], first_done());
    end
  endtask

  task automatic test_halt_restart();
    int d;
    build_model(0);
    run_frame(0, 0, 0, 0, 1'b1, 8, 400);
    total++;
    if (post_iss != 0) begin bad++; $display("FAIL halt_no_reissue: got %0d want 0", post_iss); end
    total++;
    if (obs_done_q.size() != 1 || st_s !== ST_HALT) begin
      bad++; $display("FAIL halt_state: got done=%0d state=%0d want done=1 state=3", obs_done_q.size(), st_s);
    end
    @(negedge clk); en_s = 1'b0;
    run_frame(0, 0, 0, 0, 1'b0, 4, 400);
    total++;
    if (obs_feat_q.size() == 0 || obs_feat_q[0] !== 11'd0) begin
      bad++; $display("FAIL restart_first_addr: got size %0d want first feat 0", obs_feat_q.size());
    end
    total++; d = feat_diff();
    if (d != -1) begin bad++; $display("FAIL restart_feat_seq: bad index %0d want -1", d); end
    total++; d = wr_diff();
    if (d != -1) begin bad++; $display("FAIL restart_wr_seq: bad index %0d want -1", d); end
  endtask

  task automatic test_final_stall();
    int d;
    build_model(0);
    run_frame(0, 3, 0, 0, 1'b0, 6, 400);
    total++;
    if (obs_feat_q.size() != 36) begin bad++; $display("FAIL fstall_issue_count: got %0d want 36", obs_feat_q.size()); end
    total++;
    if (obs_done_q.size() != 1) begin bad++; $display("FAIL fstall_done_count: got %0d want 1", obs_done_q.size()); end
    total++; d = wr_diff();
    if (d != -1) begin bad++; $display("FAIL fstall_wr_seq: bad index %0d want -1", d); end
    total++;
    if (first_done() - last_iss() != 3) begin
      bad++; $display("FAIL fstall_done_latency: got %0d want 3", first_done() - last_iss());
    end
  endtask

  task automatic test_random_stall();
    int d;
    build_model(0);
    for (int f = 0; f < 3; f++) begin
      run_frame(0, 1, 0, 0, 1'b0, 4, 1000);
      total++; d = feat_diff();
      if (d != -1) begin bad++; $display("FAIL rand_feat_seq f%0d: bad index %0d want -1", f, d); end
      total++; d = mac_diff();
      if (d != -1) begin bad++; $display("FAIL rand_mac_seq f%0d: bad index %0d want -1", f, d); end
      total++; d = wr_diff();
      if (d != -1) begin bad++; $display("FAIL rand_wr_seq f%0d: bad index %0d want -1", f, d); end
      total++;
      if (obs_done_q.size() != 1 || first_done() - last_iss() != 3) begin
        bad++; $display("FAIL rand_done f%0d: got n=%0d lat=%0d want n=1 lat=3",
                        f, obs_done_q.size(), first_done() - last_iss());
      end
    end
  endtask

  task automatic test_default_constant();
    int d, nclr, nlast;
    build_model(1);
    run_frame(1, 0, 0, 0, 1'b0, 4, 20000);
    nclr = 0; nlast = 0;
    foreach (obs_clr_q[i]) begin nclr += obs_clr_q[i]; nlast += obs_last_q[i]; end
    total++;
    if (obs_feat_q.size() != 19600) begin bad++; $display("FAIL def_issue_count: got %0d want 19600", obs_feat_q.size()); end
    total++;
    if (obs_wr_q.size() != 784) begin bad++; $display("FAIL def_wr_count: got %0d want 784", obs_wr_q.size()); end
    total++; d = feat_diff();
    if (d != -1) begin bad++; $display("FAIL def_feat_seq: bad index %0d want -1", d); end
    total++; d = wgt_diff();
    if (d != -1) begin bad++; $display("FAIL def_wgt_seq: bad index %0d want -1", d); end
    total++;
    if (obs_feat_q.size() == 0 || obs_feat_q[obs_feat_q.size() - 1] !== 11'd1023) begin
      bad++; $display("FAIL def_last_feat: got size %0d want last feat 1023", obs_feat_q.size());
    end
    total++;
    if (obs_wr_q.size() == 0 || obs_wr_q[obs_wr_q.size() - 1] !== 11'd783) begin
      bad++; $display("FAIL def_last_wr: got size %0d want last wr 783", obs_wr_q.size());
    end
    total++;
    if (nclr != 784 || nlast != 784) begin
      bad++; $display("FAIL def_clear_last_count: got %0d/%0d want 784/784", nclr, nlast);
    end
    total++; d = mac_diff();
    if (d != -1) begin bad++; $display("FAIL def_mac_seq: bad index %0d want -1", d); end
    total++; d = wr_diff();
    if (d != -1) begin bad++; $display("FAIL def_wr_seq: bad index %0d want -1", d); end
    total++;
    if (obs_done_q.size() != 1 || first_done() - last_iss() != 3) begin
      bad++; $display("FAIL def_done: got n=%0d lat=%0d want n=1 lat=3", obs_done_q.size(), first_done() - last_iss());
    end
  endtask

  task automatic test_stall();
    int d;
    build_model(1);
    run_frame(1, 2, 4, 3, 1'b0, 4, 20000);
    total++;
    if (obs_feat_q.size() != 19600) begin bad++; $display("FAIL stall_issue_count: got %0d want 19600", obs_feat_q.size()); end
    total++;
    if (obs_iss_cyc.size() < 5 || obs_iss_cyc[4] - obs_iss_cyc[3] != 4 || obs_feat_q[4] !== 11'd4) begin
      bad++; $display("FAIL stall_resume: got gap %0d feat %0d want gap 4 feat 4",
                      obs_iss_cyc[4] - obs_iss_cyc[3], obs_feat_q[4]);
    end
    total++;
    if (obs_mac_cyc.size() < 4 || obs_mac_cyc[3] != obs_iss_cyc[3] + 1) begin
      bad++; $display("FAIL stall_inflight_mac: got cycle %0d want %0d", obs_mac_cyc[3], obs_iss_cyc[3] + 1);
    end
    total++; d = mac_diff();
    if (d != -1) begin bad++; $display("FAIL stall_mac_seq: bad index %0d want -1", d); end
    total++; d = wr_diff();
    if (d != -1) begin bad++; $display("FAIL stall_wr_seq: bad index %0d want -1", d); end
    total++;
    if (obs_done_q.size() != 1 || first_done() - obs_iss_cyc[0] != 19600 - 1 + 3 + 3) begin
      bad++; $display("FAIL stall_frame_length: got %0d want %0d", first_done() - obs_iss_cyc[0], 19600 + 5);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_n = 1'b0; en_s = 1'b0; en_d = 1'b0;
    test_reset();
    test_small_constant();
    test_halt_restart();
    test_final_stall();
    test_random_stall();
    test_default_constant();
    test_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
- Control sequencer for one convolution layer of the cff CNN core.
- Walks a KSIZE x KSIZE window over an IMG_W x IMG_H input feature map: valid convolution, stride 1.
- Drives feature-memory and weight-memory read addresses and the MAC accumulator controls (clear/enable/last).
- Issues one output-memory write per output pixel and flags frame completion to the top level.

Parameters:
- DATA_WIDTH, 16, datapath word width; no arithmetic here, kept for top-level consistency.
- IN_FEATURE_ADDR_WIDTH, 11, feature-memory address width.
- OUT_ADDR_WIDTH, 11, output-memory address width.
- WEIGHT_ADDR_WIDTH, 5, weight-memory address width.
- IMG_W, 32, input map width.
- IMG_H, 32, input map height.
- KSIZE, 5, kernel edge; OUT_W = IMG_W-KSIZE+1, OUT_H = IMG_H-KSIZE+1.

Ports:
- clock, input, 1, single clock; all logic on rising edge.
- reset, input, 1, asynchronous, active-low; all state cleared while low.
- enable, input, 1, level; starts a frame from IDLE and stalls issue while low in RUN.
- feat_rd_en, output, 1, feature-memory read strobe.
- feat_rd_addr, output, IN_FEATURE_ADDR_WIDTH, feature-memory read address.
- wgt_rd_addr, output, WEIGHT_ADDR_WIDTH, weight-memory read address; valid with feat_rd_en.
- mac_en, output, 1, memory data valid; MAC consumes it this cycle.
- mac_clear, output, 1, with mac_en: first tap of a window; accumulator loads the product instead of adding it.
- mac_last, output, 1, with mac_en: final tap of a window.
- out_wr_en, output, 1, write the accumulator result this cycle.
- out_wr_addr, output, OUT_ADDR_WIDTH, output-memory write address.
- busy, output, 1, high in RUN and DRAIN.
- done, output, 1, one-cycle pulse at frame end.

Behaviour:
- Reset (reset=0): all outputs 0, all counters 0, FSM in IDLE. Takes effect asynchronously, including mid-frame. No partial writes occur after reset asserts.
- Counters:
  - out_row 0..OUT_H-1, out_col 0..OUT_W-1, k_row 0..KSIZE-1, k_col 0..KSIZE-1.
  - Nesting, innermost first: k_col, k_row, out_col, out_row.
- FSM states: IDLE, RUN, DRAIN, HALT.
  - IDLE -> RUN when enable=1. The first issue happens in the RUN cycle after the transition.
  - RUN: each cycle with enable=1 issues one tap:
    - feat_rd_en=1.
    - feat_rd_addr = (out_row+k_row)*IMG_W + out_col + k_col.
    - wgt_rd_addr = k_row*KSIZE + k_col.
    - Counters then advance.
  - RUN with enable=0: feat_rd_en=0 and counters hold. Taps already in flight still complete.
  - RUN -> DRAIN after issuing the final tap (all counters at maximum).
  - DRAIN -> HALT when the pipeline is empty. done=1 for exactly that transition cycle.
  - HALT -> IDLE when enable=0. Holding enable high after done never restarts the frame.
- Pipeline, fixed memory read latency of 1 cycle:
  - Tap issued at cycle t gives mac_en=1 at t+1.
  - mac_clear at t+1 iff k_row=k_col=0 at issue.
  - mac_last at t+1 iff k_row=k_col=KSIZE-1 at issue.
  - out_wr_en=1 at t+2 when mac_last was set at t+1.
  - out_wr_addr = out_row*OUT_W + out_col of that window.
  - The stage registers carry their own valid bits and tap flags. They advance every cycle regardless of enable.
- Throughput:
  - Unstalled frame: OUT_H*OUT_W*KSIZE*KSIZE consecutive issue cycles.
  - Final out_wr_en comes 2 cycles after the last issue; done 1 cycle after that.
- Width rules:
  - Addresses are unsigned.
  - Parameters must satisfy IMG_W*IMG_H <= 2^IN_FEATURE_ADDR_WIDTH, OUT_W*OUT_H <= 2^OUT_ADDR_WIDTH and KSIZE*KSIZE <= 2^WEIGHT_ADDR_WIDTH. A simulation-time check flags violations; no runtime wrap handling.
- Address generation: feature address is built incrementally with a row-base register and adders; no multiplier. The value must match the formula exactly.
- busy=1 from the first RUN cycle through the done cycle inclusive.

Decomposition:
- Shared package cnn_ctrl_pkg:
  - FSM state enum.
  - Derived localparams OUT_W, OUT_H, TAPS=KSIZE*KSIZE.
- Sub-module conv_tap_counter: the 4-level nested counter with the incremental address adder. It outputs tap address, weight address, first/last-tap flags and frame-last.
- The FSM and the 2-stage control pipeline stay in the top.

Test Plan:
- Reset: assert reset=0 mid-RUN -> all outputs 0 in the same cycle. Release and raise enable -> first feat_rd_addr=0, wgt_rd_addr=0.
- IMG_W=IMG_H=4, KSIZE=3, constant enable:
  - First 9 feat addrs are 0,1,2,4,5,6,8,9,10; next window starts at 1.
  - 36 issue cycles total.
  - out_wr_addr sequence 0,1,2,3.
  - done exactly 3 cycles after the last issue.
- Defaults (32x32, K=5):
  - 19600 issues and 784 writes.
  - Last feat addr 1023, last out_wr_addr 783.
  - mac_clear count 784, mac_last count 784.
- Stall: drop enable for 3 cycles after the 4th tap of window 0:
  - feat_rd_en low for those 3 cycles; the in-flight mac_en still appears.
  - Issue resumes at tap 5 (feat addr 4, default config).
  - Write count and addresses unchanged; frame is 3 cycles longer.
- Hold enable=1 after done -> stays in HALT, no further feat_rd_en. Drop enable 1 cycle then raise -> new frame restarts at addr 0.
- Stall coinciding with the final tap (enable low the cycle after the final issue) -> DRAIN still completes, done pulses once, no extra writes.
